// File: rtl/d_reg_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready flow control, global enable,
// synchronous flush and occupancy count. Optional parity storage: DREG_PIPE_PARITY_EN.
module d_reg_pipe #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       out_perr
);

   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0]            v_q, v_d, mv;
   logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        room0;
   logic                        in_fire;
`ifdef DREG_PIPE_PARITY_EN
   logic [DEPTH-1:0]            par_q, par_d;
`endif

   // Move flags ripple from the output end back toward stage 0.
   always_comb begin : advance
      logic room;
      mv   = '0;
      room = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         mv[i] = v_q[i] & room;
         room  = !v_q[i] | mv[i];
      end
      room0 = room;
   end

   assign in_ready = en & !flush & !reset & room0;
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
`ifdef DREG_PIPE_PARITY_EN
      par_d  = par_q;
`endif
      if (flush) begin
         v_d = '0;
      end else if (en) begin
         if (in_fire) begin
            v_d[0]    = 1'b1;
            data_d[0] = in_data;
`ifdef DREG_PIPE_PARITY_EN
            par_d[0]  = ^in_data;
`endif
         end else if (mv[0]) begin
            v_d[0] = 1'b0;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (mv[i-1]) begin
               v_d[i]    = 1'b1;
               data_d[i] = data_q[i-1];
`ifdef DREG_PIPE_PARITY_EN
               par_d[i]  = par_q[i-1];
`endif
            end else if (mv[i]) begin
               v_d[i] = 1'b0;
            end
         end
      end
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_d = count_d + CW'(v_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q     <= '0;
         data_q  <= {DEPTH{RESET_VAL}};
         count_q <= '0;
`ifdef DREG_PIPE_PARITY_EN
         par_q   <= '0;
`endif
      end else begin
         v_q     <= v_d;
         data_q  <= data_d;
         count_q <= count_d;
`ifdef DREG_PIPE_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign out_valid = v_q[DEPTH-1] & en;
   assign out_data  = data_q[DEPTH-1];
   assign count     = count_q;

`ifdef DREG_PIPE_PARITY_EN
   assign out_perr = out_valid & ((^out_data) != par_q[DEPTH-1]);
`else
   assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_d_reg_pipe.sv
// Self-checking bench for d_reg_pipe (DEPTH=4 main instance, DEPTH=1 side instance)
// against a word-position queue model.
module tb_d_reg_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset, en, flush, in_valid, out_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_ready, out_valid, out_perr;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       count;
   logic             in_ready1, out_valid1, out_perr1;
   logic [WIDTH-1:0] out_data1;
   logic [0:0]       count1;

   int n_checks = 0;
   int n_fail   = 0;

   d_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .out_perr(out_perr)
   );

   d_reg_pipe #(.WIDTH(WIDTH), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .count(count1), .out_perr(out_perr1)
   );

   always #5 clk = ~clk;

   // Reference: each word in flight carries the stage index it sits in.
   typedef struct {
      logic [WIDTH-1:0] data;
      int               pos;
   } ent_t;

   ent_t             mq[$];
   int               np[DEPTH+1];
   bit               leave;
   logic             exp_in_ready, exp_out_valid;
   logic [WIDTH-1:0] exp_out_data;
   logic [2:0]       exp_count;
   bit               occ1;
   logic [WIDTH-1:0] d1;
   logic             exp1_in_ready, exp1_out_valid;

   task automatic model_eval();
      int ahead;
      ahead         = DEPTH;
      exp_count     = 3'(mq.size());
      exp_out_valid = en && (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
      exp_out_data  = exp_out_valid ? mq[0].data : '0;
      leave         = exp_out_valid && out_ready;
      for (int k = 0; k < mq.size(); k++) begin
         if (k == 0 && leave) begin
            np[k] = DEPTH;
            continue;
         end
         np[k] = (mq[k].pos + 1 < ahead) ? mq[k].pos + 1 : mq[k].pos;
         ahead = np[k];
      end
      exp_in_ready   = en && !flush && !reset && (ahead > 0);
      exp1_out_valid = en && occ1;
      exp1_in_ready  = en && !flush && !reset && (!occ1 || out_ready);
   endtask

   task automatic model_commit();
      if (reset || flush) begin
         mq.delete();
         occ1 = 1'b0;
      end else if (en) begin
         for (int k = 0; k < mq.size(); k++) mq[k].pos = np[k];
         if (leave) void'(mq.pop_front());
         if (in_valid && exp_in_ready) mq.push_back('{data: in_data, pos: 0});
         if (occ1 && out_ready) occ1 = 1'b0;
         if (in_valid && exp1_in_ready) begin
            occ1 = 1'b1;
            d1   = in_data;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic set_in(input logic r, input logic e, input logic f,
                         input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
      reset = r; en = e; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         set_in(1, 1, 0, 1, 8'h55, 1);
         #1;
         model_eval();
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready got %b want 0", in_ready);
         end
         tick();
      end
      set_in(0, 1, 0, 0, 8'h00, 1);
      #1;
      model_eval();
      n_checks++;
      if ({out_valid, count, out_data, in_ready, out_perr} !== {1'b0, 3'd0, 8'h00, 1'b1, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL reset_state got v=%b cnt=%0d d=%h rdy=%b perr=%b want v=0 cnt=0 d=00 rdy=1 perr=0",
                  out_valid, count, out_data, in_ready, out_perr);
      end
      tick();
   endtask

   task automatic test_stream();
      int acc[$];
      for (int c = 0; c < 22; c++) begin
         if (c < 16) set_in(0, 1, 0, 1, 8'(c + 1), 1);
         else        set_in(0, 1, 0, 0, 8'h00, 1);
         #1;
         model_eval();
         n_checks++;
         if ({in_ready, out_valid, count} !== {exp_in_ready, exp_out_valid, exp_count}) begin
            n_fail++;
            $display("[TB] FAIL stream_ctl c=%0d got rdy=%b v=%b cnt=%0d want rdy=%b v=%b cnt=%0d",
                     c, in_ready, out_valid, count, exp_in_ready, exp_out_valid, exp_count);
         end
         if (exp_out_valid) begin
            n_checks++;
            if (out_data !== exp_out_data) begin
               n_fail++;
               $display("[TB] FAIL stream_data c=%0d got %h want %h", c, out_data, exp_out_data);
            end
         end
         if (out_valid && out_ready && acc.size() > 0) begin
            int a;
            a = acc.pop_front();
            n_checks++;
            if (c - a != DEPTH) begin
               n_fail++;
               $display("[TB] FAIL stream_latency got %0d want %0d", c - a, DEPTH);
            end
         end
         if (in_valid && exp_in_ready) acc.push_back(c);
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] want[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      logic [WIDTH-1:0] got[$];
      for (int c = 0; c < 5; c++) begin
         set_in(0, 1, 0, 1, want[c], 0);
         #1;
         model_eval();
         n_checks++;
         if (in_ready !== (c < 4)) begin
            n_fail++;
            $display("[TB] FAIL bp_in_ready c=%0d got %b want %b", c, in_ready, c < 4);
         end
         if (c == 4) begin
            n_checks++;
            if (count !== 3'd4) begin
               n_fail++;
               $display("[TB] FAIL bp_full_count got %0d want 4", count);
            end
         end
         tick();
      end
      for (int c = 0; c < 10; c++) begin
         set_in(0, 1, 0, (c == 0), 8'hA5, 1);
         #1;
         model_eval();
         n_checks++;
         if ({in_ready, out_valid, count} !== {exp_in_ready, exp_out_valid, exp_count}) begin
            n_fail++;
            $display("[TB] FAIL bp_ctl c=%0d got rdy=%b v=%b cnt=%0d want rdy=%b v=%b cnt=%0d",
                     c, in_ready, out_valid, count, exp_in_ready, exp_out_valid, exp_count);
         end
         if (out_valid) got.push_back(out_data);
         tick();
      end
      n_checks++;
      if (got.size() != 5) begin
         n_fail++;
         $display("[TB] FAIL bp_drain_len got %0d want 5", got.size());
      end
      for (int k = 0; k < got.size() && k < 5; k++) begin
         n_checks++;
         if (got[k] !== want[k]) begin
            n_fail++;
            $display("[TB] FAIL bp_order k=%0d got %h want %h", k, got[k], want[k]);
         end
      end
   endtask

   task automatic test_enable();
      logic [WIDTH-1:0] got[$];
      for (int c = 0; c < 2; c++) begin
         set_in(0, 1, 0, 1, 8'(8'hB1 + c), 0);
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         set_in(0, 0, 0, 1, 8'hC0, 1);
         #1;
         model_eval();
         n_checks++;
         if ({in_ready, out_valid, count} !== {1'b0, 1'b0, 3'd2}) begin
            n_fail++;
            $display("[TB] FAIL en_hold c=%0d got rdy=%b v=%b cnt=%0d want rdy=0 v=0 cnt=2",
                     c, in_ready, out_valid, count);
         end
         tick();
      end
      for (int c = 0; c < 8; c++) begin
         set_in(0, 1, 0, 0, 8'h00, 1);
         #1;
         model_eval();
         if (out_valid) got.push_back(out_data);
         tick();
      end
      n_checks++;
      if (got.size() != 2 || got[0] !== 8'hB1 || got[1] !== 8'hB2) begin
         n_fail++;
         $display("[TB] FAIL en_resume got %0d words (%h %h) want 2 words (b1 b2)",
                  got.size(), (got.size() > 0) ? got[0] : 8'h00, (got.size() > 1) ? got[1] : 8'h00);
      end
   endtask

   task automatic test_flush();
      for (int c = 0; c < 3; c++) begin
         set_in(0, 1, 0, 1, 8'(8'hD1 + c), 0);
         tick();
      end
      set_in(0, 1, 1, 1, 8'hEE, 1);
      #1;
      model_eval();
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL flush_in_ready got %b want 0", in_ready);
      end
      tick();
      for (int c = 0; c < 6; c++) begin
         set_in(0, 1, 0, 0, 8'h00, 1);
         #1;
         model_eval();
         n_checks++;
         if ({out_valid, count} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("[TB] FAIL flush_empty c=%0d got v=%b cnt=%0d want v=0 cnt=0", c, out_valid, count);
         end
         tick();
      end
   endtask

   task automatic test_parity();
      logic [WIDTH-1:0] bad_word;
      bad_word = 8'hF5 ^ 8'h01;
      set_in(0, 1, 0, 1, 8'hF5, 0);
      tick();
      for (int c = 0; c < DEPTH - 1; c++) begin
         set_in(0, 1, 0, 0, 8'h00, 0);
         tick();
      end
      #1;
      model_eval();
      n_checks++;
      if ({out_valid, out_data, out_perr} !== {1'b1, 8'hF5, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL parity_clean got v=%b d=%h perr=%b want v=1 d=f5 perr=0",
                  out_valid, out_data, out_perr);
      end
`ifdef DREG_PIPE_PARITY_EN
      force dut.data_q[DEPTH-1] = bad_word;
      #1;
      n_checks++;
      if (out_perr !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL parity_err got %b want 1", out_perr);
      end
      release dut.data_q[DEPTH-1];
`else
      n_checks++;
      if (out_perr !== 1'b0 || bad_word == out_data) begin
         n_fail++;
         $display("[TB] FAIL parity_off got %b want 0", out_perr);
      end
`endif
      @(negedge clk);
      set_in(0, 1, 1, 0, 8'h00, 0);
      #1;
      model_eval();
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
                1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
         #1;
         model_eval();
         n_checks++;
         if ({in_ready, out_valid, count, out_perr} !== {exp_in_ready, exp_out_valid, exp_count, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL rand_ctl c=%0d got rdy=%b v=%b cnt=%0d perr=%b want rdy=%b v=%b cnt=%0d perr=0",
                     c, in_ready, out_valid, count, out_perr, exp_in_ready, exp_out_valid, exp_count);
         end
         if (exp_out_valid) begin
            n_checks++;
            if (out_data !== exp_out_data) begin
               n_fail++;
               $display("[TB] FAIL rand_data c=%0d got %h want %h", c, out_data, exp_out_data);
            end
         end
         n_checks++;
         if ({in_ready1, out_valid1, count1} !== {exp1_in_ready, exp1_out_valid, 1'(occ1)}) begin
            n_fail++;
            $display("[TB] FAIL rand_d1_ctl c=%0d got rdy=%b v=%b cnt=%0d want rdy=%b v=%b cnt=%0d",
                     c, in_ready1, out_valid1, count1, exp1_in_ready, exp1_out_valid, occ1);
         end
         if (exp1_out_valid) begin
            n_checks++;
            if (out_data1 !== d1) begin
               n_fail++;
               $display("[TB] FAIL rand_d1_data c=%0d got %h want %h", c, out_data1, d1);
            end
         end
         tick();
      end
   endtask

   initial begin
      occ1 = 1'b0;
      d1   = '0;
      set_in(1, 1, 0, 0, 8'h00, 1);
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_enable();
      test_flush();
      test_parity();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
